// File: rtl/program_memory_loader_if.sv
// Bus bundle for program_memory_loader: CPU fetch address, byte-serial host
// load stream, memory write port and CPU control/status outputs.
interface program_memory_loader_if #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  load_req;
  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  cpu_restart;
  logic                  load_done;
  logic                  overflow;
  logic [ADDR_W:0]       words_loaded;
  logic [1:0]            state_dbg;

  modport master (
    output fetch_addr, load_req, load_valid, load_data,
    input  load_ready, mem_addr, mem_we, mem_wdata, cpu_hold, cpu_restart,
    input  load_done, overflow, words_loaded, state_dbg
  );

  modport slave (
    input  fetch_addr, load_req, load_valid, load_data,
    output load_ready, mem_addr, mem_we, mem_wdata, cpu_hold, cpu_restart,
    output load_done, overflow, words_loaded, state_dbg
  );
endinterface

// File: rtl/program_memory_loader.sv
// Shares the instruction memory address/write port between CPU fetch and a
// byte-serial loader that packs little-endian words from word 0 upward.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input logic                    clk,
  input logic                    reset,
  program_memory_loader_if.slave bus
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(MEMORY_DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [ADDR_W:0]       words_q, words_d;
  logic                  overflow_q, overflow_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  accept;
  logic                  full;
  logic [ADDR_W+1:0]     words_eff;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  unused_fetch_bits;

  // Handshake: a byte transfers on a rising edge where load_valid && load_ready.
  // load_ready is high only in LOAD while load_req is still high, so a byte
  // offered in the cycle load_req falls is never taken.
  assign accept = bus.load_valid && bus.load_ready;

  // A write in flight already claims its word, so count it toward full.
  assign words_eff = {1'b0, words_q} + (ADDR_W+2)'(mem_we_q);
  assign full      = (words_eff >= DEPTH_EXT);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    buf_d       = buf_q;
    words_d     = words_q;
    overflow_d  = overflow_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    asm_word    = buf_q;
    asm_word[{byte_cnt_q, 3'b000} +: 8] = bus.load_data;

    // Count advances in the cycle after the strobe, once the write has used it.
    if (mem_we_q && (words_q < DEPTH_CNT)) begin
      words_d = words_q + (ADDR_W+1)'(1);
    end

    unique case (state_q)
      S_RUN: begin
        if (bus.load_req) begin
          state_d    = S_LOAD;
          byte_cnt_d = 2'd0;
          buf_d      = '0;
          words_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!bus.load_req) begin
          if (byte_cnt_q != 2'd0) begin
            state_d     = S_COMMIT;
            mem_we_d    = !full;
            mem_wdata_d = full ? mem_wdata_q : buf_q;
          end else begin
            state_d = S_DONE;
          end
        end else if (accept) begin
          if (full) begin
            overflow_d = 1'b1;
          end else if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = asm_word;
            buf_d       = '0;
            byte_cnt_d  = 2'd0;
          end else begin
            buf_d      = asm_word;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d    = S_RUN;
        buf_d      = '0;
        byte_cnt_d = 2'd0;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      byte_cnt_q  <= 2'd0;
      buf_q       <= '0;
      words_q     <= '0;
      overflow_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      buf_q       <= buf_d;
      words_q     <= words_d;
      overflow_q  <= overflow_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.load_ready   = (state_q == S_LOAD) && bus.load_req;
  assign bus.mem_addr     = (state_q == S_RUN) ? bus.fetch_addr[ADDR_W+1:2]
                                               : words_q[ADDR_W-1:0];
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_hold     = (state_q != S_RUN);
  assign bus.cpu_restart  = (state_q == S_DONE);
  assign bus.load_done    = (state_q == S_DONE);
  assign bus.overflow     = overflow_q;
  assign bus.words_loaded = words_q;
  assign bus.state_dbg    = state_q;

  // Fetch byte offset and bits above the memory range do not select a word.
  assign unused_fetch_bits = ^{bus.fetch_addr[DATA_WIDTH-1:ADDR_W+2], bus.fetch_addr[1:0]};
endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench: two loaders (32 and 4 words) share one stimulus stream;
// a session model predicts writes and end-of-session status per depth.
module tb_program_memory_loader;
  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic        load_req;
  logic        load_valid;
  logic [7:0]  load_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] wr32_q[$];
  logic [39:0] wr4_q[$];
  logic [7:0]  done32_q[$];
  logic [7:0]  done4_q[$];
  logic [7:0]  sess_bytes[$];

  logic [39:0] mon_wr;
  logic [7:0]  mon_done;

  program_memory_loader_if #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) if32 ();
  program_memory_loader_if #(.MEMORY_DEPTH(4),  .DATA_WIDTH(32)) if4 ();

  assign if32.fetch_addr = fetch_addr;
  assign if32.load_req   = load_req;
  assign if32.load_valid = load_valid;
  assign if32.load_data  = load_data;
  assign if4.fetch_addr  = fetch_addr;
  assign if4.load_req    = load_req;
  assign if4.load_valid  = load_valid;
  assign if4.load_data   = load_data;

  program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .bus(if32.slave));
  program_memory_loader #(.MEMORY_DEPTH(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .reset(rst_n), .bus(if4.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: bytes beyond depth*4 are dropped, last word zero-padded
  task automatic expect_session(input int n);
    int depth, nb, nw;
    logic [31:0] w;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? 32 : 4;
      nb = (n > 4 * depth) ? 4 * depth : n;
      nw = (nb + 3) / 4;
      for (int k = 0; k < nw; k++) begin
        w = 32'h0;
        for (int j = 0; j < 4; j++)
          if (4 * k + j < nb) w[8*j +: 8] = sess_bytes[4*k+j];
        if (d == 0) wr32_q.push_back({8'(k), w});
        else        wr4_q.push_back({8'(k), w});
      end
      if (d == 0) done32_q.push_back({(n > 4 * depth), 7'(nw)});
      else        done4_q.push_back({(n > 4 * depth), 7'(nw)});
    end
  endtask

  function automatic bit has_partial(input int n, input int depth);
    return (n <= 4 * depth) && ((n % 4) != 0);
  endfunction

  // driver: one load session using sess_bytes
  task automatic run_session(input bit gaps, input bit late);
    int n, idx, guard;
    bit p32, p4;
    n = sess_bytes.size();
    expect_session(n);
    p32 = has_partial(n, 32);
    p4  = has_partial(n, 4);
    load_req = 1'b1;
    load_valid = 1'b0;
    @(posedge clk); #1;
    chk("entry32", {if32.cpu_hold, if32.load_ready, if32.overflow, 7'(if32.words_loaded)}, {3'b110, 7'd0});
    chk("entry4",  {if4.cpu_hold,  if4.load_ready,  if4.overflow,  7'(if4.words_loaded)},  {3'b110, 7'd0});
    idx = 0;
    guard = 0;
    while (idx < n && guard < 4 * n + 100) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data  = sess_bytes[idx];
        if (!gaps) chk("ready4_stays_high", 64'(if4.load_ready), 64'd1);
        if (if32.load_ready) idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (idx < n) chk("byte_accept_timeout", 64'(idx), 64'(n));
    load_req   = 1'b0;
    load_valid = late;
    load_data  = 8'hDD;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("end32", {if32.cpu_hold, if32.load_done},
          p32 ? {(k <= 1), (k == 1)} : {(k == 0), (k == 0)});
      chk("end4", {if4.cpu_hold, if4.load_done},
          p4 ? {(k <= 1), (k == 1)} : {(k == 0), (k == 0)});
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (if32.mem_we) begin
        if (wr32_q.size() == 0) chk("wr32_unexpected", {8'(if32.mem_addr), if32.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mon_wr = wr32_q.pop_front();
          chk("wr32", {8'(if32.mem_addr), if32.mem_wdata}, mon_wr);
        end
      end
      if (if4.mem_we) begin
        if (wr4_q.size() == 0) chk("wr4_unexpected", {8'(if4.mem_addr), if4.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mon_wr = wr4_q.pop_front();
          chk("wr4", {8'(if4.mem_addr), if4.mem_wdata}, mon_wr);
        end
      end
      if (if32.load_done) begin
        if (done32_q.size() == 0) chk("done32_unexpected", 64'(if32.load_done), 64'd0);
        else begin
          mon_done = done32_q.pop_front();
          chk("done32", {if32.cpu_restart, if32.overflow, 7'(if32.words_loaded)}, {1'b1, mon_done});
        end
      end
      if (if4.load_done) begin
        if (done4_q.size() == 0) chk("done4_unexpected", 64'(if4.load_done), 64'd0);
        else begin
          mon_done = done4_q.pop_front();
          chk("done4", {if4.cpu_restart, if4.overflow, 7'(if4.words_loaded)}, {1'b1, mon_done});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fetch_addr = 32'h0000_0014;
    load_req = 1'b0;
    load_valid = 1'b0;
    load_data = 8'h00;
    #2;
    chk("rst_addr32", 64'(if32.mem_addr), 64'd5);
    chk("rst_addr4",  64'(if4.mem_addr),  64'd1);
    chk("rst_out32", {if32.cpu_hold, if32.mem_we, if32.cpu_restart, if32.load_done,
                      if32.overflow, if32.load_ready, 7'(if32.words_loaded)}, 64'd0);
    chk("rst_out4",  {if4.cpu_hold, if4.mem_we, if4.cpu_restart, if4.load_done,
                      if4.overflow, if4.load_ready, 7'(if4.words_loaded)}, 64'd0);
    chk("rst_wdata32", 64'(if32.mem_wdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RUN address passthrough
    for (int i = 0; i < 8; i++) begin
      fetch_addr = $urandom;
      #1;
      chk("fetch32", 64'(if32.mem_addr), 64'((fetch_addr >> 2) % 32));
      chk("fetch4",  64'(if4.mem_addr),  64'((fetch_addr >> 2) % 4));
      @(posedge clk); #1;
    end

    sess_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_session(1'b0, 1'b0);

    sess_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_session(1'b0, 1'b0);

    sess_bytes.delete();
    for (int i = 0; i < 20; i++) sess_bytes.push_back(8'($urandom));
    run_session(1'b0, 1'b0);
    chk("ovf_sticky4", 64'(if4.overflow), 64'd1);

    // reset in the middle of a session
    load_req = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'h11;
    @(posedge clk); #1;
    load_data = 8'h22;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst32", {if32.cpu_hold, if32.mem_we, if32.cpu_restart, 7'(if32.words_loaded)}, 64'd0);
    chk("midrst4",  {if4.cpu_hold,  if4.mem_we,  if4.cpu_restart,  if4.overflow}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sess_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_session(1'b0, 1'b0);

    // byte offered as load_req falls is dropped
    sess_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_session(1'b0, 1'b1);

    for (int s = 0; s < 8; s++) begin
      sess_bytes.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) sess_bytes.push_back(8'($urandom));
      run_session(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("wr32_left",   64'(wr32_q.size()),   64'd0);
    chk("wr4_left",    64'(wr4_q.size()),    64'd0);
    chk("done32_left", 64'(done32_q.size()), 64'd0);
    chk("done4_left",  64'(done4_q.size()),  64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
